// File: rtl/clk_mon.sv
`default_nettype none
// ============================================================================
//  Module      : clk_mon
//  Description : Monitors a slow clock, sampled as asynchronous data in the
//                clk_sys domain. Measures each slow period and qualifies the
//                clock as OK after GOOD_N consecutive in-tolerance periods.
//                Enters FAIL on a bad period or a missing edge, and counts
//                the number of times it has entered FAIL.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_mon #(
    parameter int unsigned NOM     = 100,
    parameter int unsigned TOL     = 2,
    parameter int unsigned GOOD_N  = 4,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       slow_in,
    input  logic       clr_fault,
    output logic       slow_tick,
    output logic [7:0] period,
    output logic       period_vld,
    output logic       clk_ok,
    output logic       fault,
    output logic [7:0] fault_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_OK   = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [7:0] PER_LO   = 8'(NOM - TOL);
    localparam logic [7:0] PER_HI   = 8'(NOM + TOL);
    localparam logic [7:0] TMO_VAL  = 8'(TIMEOUT);
    localparam logic [3:0] GOOD_TGT = 4'(GOOD_N);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [7:0] r_cnt;
    logic [2:0] r_good_cnt;
    logic [1:0] r_state;

    logic       w_rise;
    logic       w_good;
    logic       w_timeout;
    logic [3:0] w_good_inc;
    logic [1:0] w_state_nxt;
    logic [2:0] w_good_nxt;
    logic       w_upd;
    logic       w_clr;
    logic [7:0] w_cnt_nxt;

    // Edge detect on the synchronized copy of slow_in.
    assign w_rise     = r_s2 & ~r_s3;
    // The registered tick is the only event the rest of the monitor sees.
    assign w_good     = (r_cnt >= PER_LO) && (r_cnt <= PER_HI);
    assign w_timeout  = (r_cnt == TMO_VAL) && !slow_tick;
    assign w_good_inc = {1'b0, r_good_cnt} + 4'd1;
    assign w_clr      = (r_state == S_FAIL) && clr_fault;

    // Two-flop synchronizer, edge-detect flop and registered tick.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            slow_tick <= 1'b0;
        end else begin
            r_s1      <= slow_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            slow_tick <= w_rise;
        end
    end

    // Period counter: restarts at 1 on each tick, saturates, cleared on exit from FAIL.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_clr) begin
            w_cnt_nxt = 8'd0;
        end else if (slow_tick) begin
            w_cnt_nxt = 8'd1;
        end else if (r_cnt != 8'd255) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    // Monitor state transitions; a tick takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_upd       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (slow_tick) begin
                    w_state_nxt = S_MEAS;
                    w_good_nxt  = 3'd0;
                end else if (w_timeout) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_MEAS: begin
                if (slow_tick) begin
                    w_upd = 1'b1;
                    if (w_good) begin
                        w_good_nxt = w_good_inc[2:0];
                        if (w_good_inc == GOOD_TGT) begin
                            w_state_nxt = S_OK;
                        end
                    end else begin
                        w_good_nxt = 3'd0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_OK: begin
                if (slow_tick) begin
                    w_upd = 1'b1;
                    if (!w_good) begin
                        w_state_nxt = S_FAIL;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_FAIL;
                end
            end
            default: begin
                if (clr_fault) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_good_cnt <= 3'd0;
            period     <= 8'd0;
            period_vld <= 1'b0;
            clk_ok     <= 1'b0;
            fault      <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_good_cnt <= w_good_nxt;
            period_vld <= w_upd;
            if (w_upd) begin
                period <= r_cnt;
            end
            clk_ok <= (w_state_nxt == S_OK);
            fault  <= (w_state_nxt == S_FAIL);
            if ((w_state_nxt == S_FAIL) && (r_state != S_FAIL) && (fault_cnt != 8'd255)) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_mon
//  Description : Directed self-checking bench for clk_mon.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_mon;

    logic       clk_sys   = 1'b0;
    logic       rst       = 1'b1;
    logic       slow_in   = 1'b0;
    logic       clr_fault = 1'b0;
    logic       slow_tick;
    logic [7:0] period;
    logic       period_vld;
    logic       clk_ok;
    logic       fault;
    logic [7:0] fault_cnt;

    int vectors     = 0;
    int miscompares = 0;

    clk_mon #(
        .NOM     (100),
        .TOL     (2),
        .GOOD_N  (4),
        .TIMEOUT (200)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .slow_in    (slow_in),
        .clr_fault  (clr_fault),
        .slow_tick  (slow_tick),
        .period     (period),
        .period_vld (period_vld),
        .clk_ok     (clk_ok),
        .fault      (fault),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Raise slow_in; after 4 edges the resulting tick has been consumed.
    task automatic rise4();
        slow_in = 1'b1;
        cyc(4);
    endtask

    // Complete a slow period of p cycles started by rise4.
    task automatic finish(input int p);
        cyc(p / 2 - 4);
        slow_in = 1'b0;
        cyc(p - p / 2);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_tick"}, int'(slow_tick), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_vld"}, int'(period_vld), 0);
        chk({tag, "_ok"}, int'(clk_ok), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_fcnt"}, int'(fault_cnt), 0);
    endtask

    initial begin
        // Reset values.
        cyc(3);
        all_zero("rst");

        // slow_in held low: timeout at cnt==200, FAIL on the following edge.
        rst = 1'b0;
        cyc(200);
        chk("tmo_pre", int'(fault), 0);
        cyc(1);
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_fcnt", int'(fault_cnt), 1);

        // Reset from FAIL.
        rst = 1'b1;
        cyc(1);
        all_zero("rst_fail");
        cyc(1);
        rst = 1'b0;

        // First rise: tick latency and no period on the first tick.
        slow_in = 1'b1;
        cyc(2);
        chk("tick_e2", int'(slow_tick), 0);
        cyc(1);
        chk("tick_e3", int'(slow_tick), 1);
        cyc(1);
        chk("tick_e4", int'(slow_tick), 0);
        chk("first_vld", int'(period_vld), 0);
        finish(100);

        // Good ticks 2..4 still in MEAS.
        for (int i = 2; i <= 4; i++) begin
            rise4();
            chk("meas_vld", int'(period_vld), 1);
            chk("meas_per", int'(period), 100);
            chk("meas_ok", int'(clk_ok), 0);
            finish(100);
        end
        rise4();
        chk("ok5", int'(clk_ok), 1);
        chk("ok5_fault", int'(fault), 0);
        finish(100);

        // One long period while OK.
        rise4();
        chk("ok6", int'(clk_ok), 1);
        finish(103);
        rise4();
        chk("bad_fault", int'(fault), 1);
        chk("bad_ok", int'(clk_ok), 0);
        chk("bad_per", int'(period), 103);
        chk("bad_vld", int'(period_vld), 1);
        chk("bad_fcnt", int'(fault_cnt), 1);
        finish(100);

        // Tick in FAIL updates nothing visible.
        rise4();
        chk("failtick_vld", int'(period_vld), 0);
        chk("failtick_per", int'(period), 103);
        chk("failtick_fault", int'(fault), 1);
        finish(100);

        // clr_fault coincident with a tick.
        slow_in = 1'b1;
        cyc(3);
        clr_fault = 1'b1;
        cyc(1);
        clr_fault = 1'b0;
        chk("clr_fault", int'(fault), 0);
        chk("clr_ok", int'(clk_ok), 0);
        chk("clr_vld", int'(period_vld), 0);
        chk("clr_fcnt", int'(fault_cnt), 1);
        finish(100);

        // Next tick leaves IDLE, then periods 98, 102, 97.
        rise4();
        chk("idle_vld", int'(period_vld), 0);
        finish(98);
        rise4();
        chk("p98", int'(period), 98);
        chk("p98_vld", int'(period_vld), 1);
        finish(102);
        rise4();
        chk("p102", int'(period), 102);
        finish(97);
        rise4();
        chk("p97", int'(period), 97);
        chk("p97_ok", int'(clk_ok), 0);
        finish(100);
        for (int k = 1; k <= 3; k++) begin
            rise4();
            chk("regood_ok", int'(clk_ok), 0);
            finish(100);
        end
        rise4();
        chk("regood_ok4", int'(clk_ok), 1);

        // clr_fault in OK is ignored; then timeout from OK.
        slow_in   = 1'b0;
        clr_fault = 1'b1;
        cyc(1);
        clr_fault = 1'b0;
        chk("clr_in_ok", int'(clk_ok), 1);
        cyc(197);
        chk("oktmo_199", int'(fault), 0);
        cyc(1);
        chk("oktmo_200", int'(fault), 0);
        chk("oktmo_200_ok", int'(clk_ok), 1);
        cyc(1);
        chk("oktmo_fault", int'(fault), 1);
        chk("oktmo_ok", int'(clk_ok), 0);
        chk("oktmo_fcnt", int'(fault_cnt), 2);

        // Clear, then timeout from IDLE.
        clr_fault = 1'b1;
        cyc(1);
        clr_fault = 1'b0;
        chk("clr2_fault", int'(fault), 0);
        cyc(200);
        chk("idletmo_pre", int'(fault), 0);
        cyc(1);
        chk("idletmo_fault", int'(fault), 1);
        chk("idletmo_fcnt", int'(fault_cnt), 3);

        // Back to OK, then reset while OK.
        clr_fault = 1'b1;
        cyc(1);
        clr_fault = 1'b0;
        rise4();
        finish(100);
        for (int k = 1; k <= 3; k++) begin
            rise4();
            chk("rq_ok", int'(clk_ok), 0);
            finish(100);
        end
        rise4();
        chk("rq_ok4", int'(clk_ok), 1);
        chk("rq_fcnt", int'(fault_cnt), 3);
        slow_in = 1'b0;
        rst     = 1'b1;
        cyc(1);
        all_zero("rst_ok");
        rst = 1'b0;

        // Monitoring restarts: first tick gives no period.
        rise4();
        chk("restart_vld", int'(period_vld), 0);
        chk("restart_ok", int'(clk_ok), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 Parameter NOM, 100, nominal clk_slow period in clk_sys cycles.
REQ-002 Parameter TOL, 2, accepted deviation from NOM in cycles (inclusive).
REQ-003 Parameter GOOD_N, 4, consecutive good periods required to declare clock OK.
REQ-004 Parameter TIMEOUT, 200, cycles without a slow edge before fault; constraint NOM+TOL < TIMEOUT <= 255.
REQ-005 clk_sys  in  1  system clock (100 MHz); single clock domain.
REQ-006 rst  in  1  reset: synchronous to clk_sys, active-high.
REQ-007 slow_in  in  1  clk_slow (1 MHz) routed as asynchronous data, monitored only.
REQ-008 clr_fault  in  1  one-cycle request: leave FAIL and restart monitoring.
REQ-009 slow_tick  out  1  one-cycle pulse per synchronized slow_in rising edge.
REQ-010 period  out  8  last measured slow period in clk_sys cycles.
REQ-011 period_vld  out  1  one-cycle pulse when period updates.
REQ-012 clk_ok  out  1  high while state is OK.
REQ-013 fault  out  1  high while state is FAIL.
REQ-014 fault_cnt  out  8  count of entries into FAIL, saturating at 255.

Function
REQ-015 slow_in shall pass through a 2-flop synchronizer plus a third flop for edge detect; rise = s2 & ~s3.
REQ-016 slow_tick shall be registered: high for exactly one cycle, 3 clk_sys edges after the first edge sampling slow_in high.
REQ-017 Counter cnt (8 bit) shall load 1 on a tick, otherwise increment, saturating at 255.
REQ-018 On a tick in MEAS, OK, or FAIL-exempt states (MEAS, OK), period <= cnt and period_vld pulses the next cycle; no update on the first tick out of IDLE.
REQ-019 Good period: NOM-TOL <= cnt <= NOM+TOL at the tick; otherwise bad.
REQ-020 Timeout: cnt == TIMEOUT with no tick in that cycle.
REQ-021 States: IDLE, MEAS, OK, FAIL; good_cnt (3 bit) counts good periods in MEAS.
REQ-022 IDLE: tick -> MEAS, good_cnt <= 0; timeout -> FAIL.
REQ-023 MEAS: good tick -> good_cnt+1, -> OK when good_cnt+1 == GOOD_N; bad tick -> good_cnt <= 0, stay MEAS; timeout -> FAIL.
REQ-024 OK: bad tick or timeout -> FAIL; good tick -> stay OK.
REQ-025 FAIL: stay until clr_fault; clr_fault -> IDLE, cnt <= 0; ticks in FAIL update nothing but cnt.
REQ-026 Tick and timeout in the same cycle: tick wins, period judged normally.
REQ-027 clr_fault and tick in the same cycle: clr_fault wins, tick ignored (no period_vld).
REQ-028 clr_fault outside FAIL shall be ignored.
REQ-029 clk_ok and fault shall be registered decodes of state, valid the cycle after the transition.
REQ-030 fault_cnt shall increment on every transition into FAIL; only rst clears it.

Reset
REQ-031 On rst: state IDLE, cnt 0, good_cnt 0, sync flops 0, slow_tick 0, period 0, period_vld 0, clk_ok 0, fault 0, fault_cnt 0.
REQ-032 rst asserted mid-operation (any state) shall force the reset values on the next clk_sys edge; monitoring restarts from IDLE.
REQ-033 No output shall depend on rst combinationally.

Verification
REQ-034 slow_in square wave, period 100 cycles -> first tick enters MEAS; clk_ok=1 one cycle after 5th tick; period=100, period_vld each tick after the first.
REQ-035 In OK, one period of 103 -> fault=1, clk_ok=0 cycle after that tick; fault_cnt=1; period=103.
REQ-036 slow_in held low after reset -> fault=1 after cnt reaches 200 (about 201 edges after rst release); fault_cnt=1.
REQ-037 In MEAS periods 98,102,97 -> first two counted good, 97 resets good_cnt; clk_ok needs 4 further good periods.
REQ-038 In FAIL, clr_fault coincident with tick -> IDLE, no period_vld; next tick -> MEAS; fault_cnt unchanged.
REQ-039 rst pulsed while OK with fault_cnt=3 -> all outputs 0 next edge, fault_cnt=0.
